// File: rtl/motor_ctrl_pkg.sv
// motor_ctrl_pkg -- shared widths and state encoding for the motor command path.
//   SAMPLE_W     : accelerometer sample width (signed)
//   CMD_W        : duty command width, shared with the PWM stage
//   CMD_MAX      : largest duty command
//   filt_state_t : command filter states {PRIME, RUN, BRAKE}
package motor_ctrl_pkg;

    localparam int SAMPLE_W = 12;
    localparam int CMD_W    = 10;
    localparam logic [CMD_W-1:0] CMD_MAX = 10'd1023;

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        RUN   = 2'd1,
        BRAKE = 2'd2
    } filt_state_t;

endpackage

// File: rtl/sample_averager.sv
// sample_averager -- power-of-two moving-window sum of signed samples.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   sample        : signed sample, accepted when sample_valid is high
//   sample_valid  : one-cycle accept strobe (may be high every clock)
//   sum           : signed running sum of the last 2^AVG_LOG2 samples
//   primed        : sticky, set once 2^AVG_LOG2 samples have been accepted
module sample_averager
    import motor_ctrl_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [SAMPLE_W-1:0]                sample,
    input  logic                               sample_valid,
    output logic signed [SAMPLE_W+AVG_LOG2-1:0] sum,
    output logic                               primed
);

    localparam int WIN   = 1 << AVG_LOG2;
    localparam int SUM_W = SAMPLE_W + AVG_LOG2;

    logic [WIN-1:0][SAMPLE_W-1:0] ring;
    logic [AVG_LOG2-1:0]          wr_ptr;
    logic [AVG_LOG2:0]            fill;
    logic signed [SUM_W-1:0]      sum_next;

    // Add the newcomer and drop the entry it overwrites (the oldest).
    assign sum_next = sum + SUM_W'($signed(sample)) - SUM_W'($signed(ring[wr_ptr]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring   <= '0;
            wr_ptr <= '0;
            fill   <= '0;
            sum    <= '0;
            primed <= 1'b0;
        end else if (sample_valid) begin
            ring[wr_ptr] <= sample;
            wr_ptr       <= wr_ptr + 1'b1;   // window is a power of two: natural wrap
            sum          <= sum_next;
            if (!primed) begin
                fill <= fill + 1'b1;
                if (fill == (AVG_LOG2+1)'(WIN - 1))
                    primed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/motor_cmd_filter.sv
// motor_cmd_filter -- turns raw accelerometer samples into the PWM duty command.
// Average over 2^AVG_LOG2 samples, deadband, clamp to 0..CMD_MAX, optional
// ramp limit on increases, brake forces zero.
// Build option: define MOTOR_RAMP_LIMIT_EN to rate-limit increases to
// RAMP_STEP per RAMP_DIV clocks; otherwise the command follows the target.
// Ports:
//   CLOCK_50, RESET_n : 50 MHz clock, asynchronous active-low reset
//   SAMPLE            : signed accelerometer sample
//   SAMPLE_VALID      : one-cycle strobe for SAMPLE
//   BRAKE             : level, forces the command to zero
//   PWMinput          : duty command to the PWM stage
//   CMD_VALID         : high in RUN (window primed, not braking)
module motor_cmd_filter
    import motor_ctrl_pkg::*;
#(
    parameter int AVG_LOG2  = 3,
    parameter int DEADBAND  = 40,
    parameter int RAMP_DIV  = 50000,
    parameter int RAMP_STEP = 8
) (
    input  logic                CLOCK_50,
    input  logic                RESET_n,
    input  logic [SAMPLE_W-1:0] SAMPLE,
    input  logic                SAMPLE_VALID,
    input  logic                BRAKE,
    output logic [CMD_W-1:0]    PWMinput,
    output logic                CMD_VALID
);

    localparam int SUM_W = SAMPLE_W + AVG_LOG2;
    localparam logic signed [SUM_W-1:0] DB    = SUM_W'(DEADBAND);
    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(CMD_MAX);

    logic signed [SUM_W-1:0] sum, avg, excess;
    logic                    primed;
    logic [CMD_W-1:0]        target, target_next, up_val, pwm_d;
    filt_state_t             state_q, state_d;

    sample_averager #(.AVG_LOG2(AVG_LOG2)) u_avg (
        .clk          (CLOCK_50),
        .rst_n        (RESET_n),
        .sample       (SAMPLE),
        .sample_valid (SAMPLE_VALID),
        .sum          (sum),
        .primed       (primed)
    );

    // Arithmetic shift: truncates toward -inf, so small negatives stay negative.
    assign avg    = sum >>> AVG_LOG2;
    assign excess = avg - DB;

    always_comb begin
        target_next = '0;
        if (avg > DB)
            target_next = (excess > MAX_S) ? CMD_MAX : excess[CMD_W-1:0];
    end

`ifdef MOTOR_RAMP_LIMIT_EN
    localparam int RC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [RC_W-1:0]  ramp_cnt;
    logic             ramp_tick;
    logic [CMD_W-1:0] room, step;

    assign ramp_tick = (ramp_cnt == RC_W'(RAMP_DIV - 1));

    // Free-running divider, independent of state.
    always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
        if (!RESET_n)       ramp_cnt <= '0;
        else if (ramp_tick) ramp_cnt <= '0;
        else                ramp_cnt <= ramp_cnt + 1'b1;
    end

    // Only consulted when target >= PWMinput, so room never underflows.
    always_comb begin
        room   = target - PWMinput;
        step   = (room > CMD_W'(RAMP_STEP)) ? CMD_W'(RAMP_STEP) : room;
        up_val = ramp_tick ? PWMinput + step : PWMinput;
    end
`else
    logic unused_ramp_cfg;
    assign unused_ramp_cfg = ^{RAMP_DIV, RAMP_STEP};
    assign up_val = target;
`endif

    always_comb begin
        state_d = state_q;
        pwm_d   = PWMinput;
        unique case (state_q)
            PRIME: begin
                pwm_d = '0;
                if (primed) state_d = BRAKE ? motor_ctrl_pkg::BRAKE : RUN;
            end
            RUN: begin
                if (BRAKE) begin
                    state_d = motor_ctrl_pkg::BRAKE;
                    pwm_d   = '0;
                end else if (target < PWMinput) begin
                    pwm_d = target;        // decreases are never rate-limited
                end else begin
                    pwm_d = up_val;
                end
            end
            motor_ctrl_pkg::BRAKE: begin
                pwm_d = '0;                // released brake ramps up from zero
                if (!BRAKE) state_d = RUN;
            end
            default: begin
                state_d = PRIME;
                pwm_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= PRIME;
            target    <= '0;
            PWMinput  <= '0;
            CMD_VALID <= 1'b0;
        end else begin
            state_q   <= state_d;
            target    <= target_next;
            PWMinput  <= pwm_d;
            CMD_VALID <= (state_d == RUN);
        end
    end

endmodule

// File: tb/tb_motor_cmd_filter.sv
// tb_motor_cmd_filter -- directed self-checking bench for motor_cmd_filter.
// Default build checks the unramped path; with MOTOR_RAMP_LIMIT_EN defined
// it checks the ramp with RAMP_DIV=4, RAMP_STEP=8.
module tb_motor_cmd_filter;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_n;
    logic [11:0] SAMPLE;
    logic        SAMPLE_VALID;
    logic        BRAKE;
    logic [9:0]  PWMinput;
    logic        CMD_VALID;

    int n_vec = 0;
    int n_err = 0;

    motor_cmd_filter #(
        .AVG_LOG2  (3),
        .DEADBAND  (40),
        .RAMP_DIV  (4),
        .RAMP_STEP (8)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .RESET_n      (RESET_n),
        .SAMPLE       (SAMPLE),
        .SAMPLE_VALID (SAMPLE_VALID),
        .BRAKE        (BRAKE),
        .PWMinput     (PWMinput),
        .CMD_VALID    (CMD_VALID)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic feed(input int v);
        SAMPLE       = 12'(v);
        SAMPLE_VALID = 1'b1;
        tick(1);
        SAMPLE_VALID = 1'b0;
    endtask

    task automatic feed8(input int v);
        repeat (8) feed(v);
    endtask

`ifdef MOTOR_RAMP_LIMIT_EN
    int prev, before, last_c, cyc;
`endif

    initial begin
        RESET_n      = 1'b0;
        SAMPLE       = '0;
        SAMPLE_VALID = 1'b0;
        BRAKE        = 1'b0;
        #25;
        chk("reset_pwm", 32'(PWMinput), 32'd0);
        chk("reset_cmd_valid", 32'(CMD_VALID), 32'd0);
        @(posedge CLOCK_50);
        #1;
        RESET_n = 1'b1;
        tick(1);

`ifdef MOTOR_RAMP_LIMIT_EN
        // Prime at zero, then step to avg 140 -> target 100.
        feed8(0);
        tick(2);
        chk("prime0_pwm", 32'(PWMinput), 32'd0);
        chk("prime0_cmd_valid", 32'(CMD_VALID), 32'd1);

        feed8(140);
        prev   = int'(PWMinput);
        before = prev;
        last_c = -1;
        cyc    = 0;
        while (PWMinput != 10'd100 && cyc < 200) begin
            tick(1);
            cyc++;
            if (int'(PWMinput) != prev) begin
                chk("ramp_step", 32'(PWMinput), 32'((prev + 8 > 100) ? 100 : prev + 8));
                if (last_c >= 0) chk("ramp_gap", 32'(cyc - last_c), 32'd4);
                last_c = cyc;
                before = prev;
                prev   = int'(PWMinput);
            end
        end
        chk("ramp_final", 32'(PWMinput), 32'd100);
        chk("ramp_last_from", 32'(before), 32'd96);

        // Drop to the deadband edge: no rate limit on the way down.
        feed8(40);
        tick(2);
        chk("ramp_drop", 32'(PWMinput), 32'd0);

        // Climb to 460, brake, release: restart from zero, one step per tick.
        feed8(500);
        cyc = 0;
        while (PWMinput != 10'd460 && cyc < 400) begin
            tick(1);
            cyc++;
        end
        chk("ramp_reach_460", 32'(PWMinput), 32'd460);
        BRAKE = 1'b1;
        tick(1);
        chk("ramp_brake_pwm", 32'(PWMinput), 32'd0);
        chk("ramp_brake_cmd_valid", 32'(CMD_VALID), 32'd0);
        BRAKE = 1'b0;
        tick(1);
        chk("ramp_release_pwm", 32'(PWMinput), 32'd0);
        chk("ramp_release_cmd_valid", 32'(CMD_VALID), 32'd1);
        tick(4);
        chk("ramp_release_first_step", 32'(PWMinput), 32'd8);
`else
        // Priming: seven samples leave the output idle.
        repeat (7) feed(500);
        tick(3);
        chk("prime7_pwm", 32'(PWMinput), 32'd0);
        chk("prime7_cmd_valid", 32'(CMD_VALID), 32'd0);
        // Eighth sample: command 500-40=460 three clocks after it is driven.
        feed(500);
        tick(1);
        chk("latency_k2_pwm", 32'(PWMinput), 32'd0);
        tick(1);
        chk("latency_k3_pwm", 32'(PWMinput), 32'd460);
        chk("run_cmd_valid", 32'(CMD_VALID), 32'd1);

        // Brake (with a sample the same cycle), then release.
        BRAKE = 1'b1;
        tick(1);
        chk("brake_pwm", 32'(PWMinput), 32'd0);
        chk("brake_cmd_valid", 32'(CMD_VALID), 32'd0);
        feed(500);
        chk("brake_hold_pwm", 32'(PWMinput), 32'd0);
        BRAKE = 1'b0;
        tick(1);
        chk("release_pwm", 32'(PWMinput), 32'd0);
        chk("release_cmd_valid", 32'(CMD_VALID), 32'd1);
        tick(1);
        chk("release_follow", 32'(PWMinput), 32'd460);

        // Asynchronous reset mid-run, then re-prime.
        RESET_n = 1'b0;
        #1;
        chk("async_reset_pwm", 32'(PWMinput), 32'd0);
        chk("async_reset_cmd_valid", 32'(CMD_VALID), 32'd0);
        #2;
        RESET_n = 1'b1;
        tick(1);
        repeat (7) feed(500);
        tick(3);
        chk("reprime7_pwm", 32'(PWMinput), 32'd0);
        chk("reprime7_cmd_valid", 32'(CMD_VALID), 32'd0);
        feed(500);
        tick(2);
        chk("reprime8_pwm", 32'(PWMinput), 32'd460);

        // Deadband and negative averages.
        feed8(20);
        tick(2);
        chk("avg20_pwm", 32'(PWMinput), 32'd0);
        for (int i = 0; i < 8; i++) begin
            feed(-300);
            tick(2);
            chk("neg300_pwm", 32'(PWMinput), 32'd0);
        end
        feed8(-2048);
        tick(2);
        chk("neg_min_pwm", 32'(PWMinput), 32'd0);
        feed8(40);
        tick(2);
        chk("deadband_edge", 32'(PWMinput), 32'd0);
        feed8(41);
        tick(2);
        chk("deadband_plus1", 32'(PWMinput), 32'd1);
        // Sum 7*41+48=335 -> avg 41 (truncated) -> 1.
        feed(48);
        tick(2);
        chk("avg_truncate", 32'(PWMinput), 32'd1);

        // Clamp boundaries.
        feed8(1062);
        tick(2);
        chk("clamp_below", 32'(PWMinput), 32'd1022);
        feed8(1063);
        tick(2);
        chk("clamp_exact", 32'(PWMinput), 32'd1023);
        feed8(2047);
        tick(2);
        chk("clamp_max", 32'(PWMinput), 32'd1023);

        // Immediate decrease from full scale.
        feed8(500);
        tick(2);
        chk("decrease_pwm", 32'(PWMinput), 32'd460);
        chk("final_cmd_valid", 32'(CMD_VALID), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
